// File: rtl/prog_delay_timer.sv
// Multi-channel programmable delay timer: each channel counts a latched delay
// down to zero and emits a one-cycle time_out pulse, in one-shot or periodic mode.

module prog_delay_timer_ch #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] n,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             hold,
  output logic             time_out,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             mode;

  // Priority: stop > hold > start > countdown. time_out defaults low so the
  // pulse is always exactly one cycle wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      reload   <= '0;
      mode     <= 1'b0;
      time_out <= 1'b0;
    end else begin
      time_out <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else if (!hold) begin
        if (start) begin
          count  <= n;
          reload <= n;
          mode   <= periodic;
          state  <= RUN;
        end else if (state == RUN) begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            time_out <= 1'b1;
            if (mode) count <= reload;
            else      state <= IDLE;
          end
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

module prog_delay_timer #(
  parameter int WIDTH    = 14,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] n,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic                      hold,
  output logic [CHANNELS-1:0]       time_out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*WIDTH-1:0] count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    prog_delay_timer_ch #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .n        (n[i*WIDTH +: WIDTH]),
      .start    (start[i]),
      .stop     (stop[i]),
      .periodic (periodic[i]),
      .hold     (hold),
      .time_out (time_out[i]),
      .busy     (busy[i]),
      .count    (count[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/prog_delay_timer.md
PROG_DELAY_TIMER -- requirements
Module: prog_delay_timer

Interface
REQ-001 Parameter WIDTH, default 14, SHALL set the bit width of each channel's delay count.
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of independent timer channels.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 n  input  CHANNELS*WIDTH  SHALL carry the per-channel delay value; channel i SHALL use bits [i*WIDTH +: WIDTH].
REQ-006 start  input  CHANNELS  SHALL carry the per-channel start/retrigger request, sampled each edge.
REQ-007 stop  input  CHANNELS  SHALL carry the per-channel abort request.
REQ-008 periodic  input  CHANNELS  SHALL select the per-channel mode: 0 = one-shot, 1 = periodic.
REQ-009 hold  input  1  SHALL be a global freeze; 1 = all channels paused.
REQ-010 time_out  output  CHANNELS  SHALL carry a one-cycle expiry pulse per channel.
REQ-011 busy  output  CHANNELS  SHALL be 1 while a channel is in RUN.
REQ-012 count  output  CHANNELS*WIDTH  SHALL expose each channel's current down-counter.

Function
REQ-013 Each channel SHALL implement a two-state FSM, IDLE/RUN, with registers cnt, reload (WIDTH bits) and mode (1 bit).
REQ-014 IDLE, start=1, hold=0: on the next edge the channel SHALL set cnt<=n_i, reload<=n_i, mode<=periodic_i and go to RUN.
REQ-015 RUN, hold=0, no start/stop, cnt!=0: on each edge the channel SHALL set cnt<=cnt-1.
REQ-016 RUN, hold=0, no start/stop, cnt==0: the channel SHALL register time_out_i=1 for exactly one cycle.
REQ-017 In the REQ-016 case, if mode=1 the channel SHALL set cnt<=reload and remain in RUN.
REQ-018 In the REQ-016 case, if mode=0 the channel SHALL go to IDLE with cnt unchanged (0).
REQ-019 Latency: when start is sampled at edge E0, time_out SHALL be high in the cycle after edge E0+N+1, with no hold.
REQ-020 n=0 SHALL give time_out one cycle after the first RUN cycle (edge E0+1).
REQ-021 Periodic mode SHALL produce one pulse every N+1 cycles.
REQ-022 The channel SHALL use only the latched reload and mode values; changes on n or periodic SHALL have no effect until the next start.
REQ-023 RUN, start=1, hold=0: the channel SHALL reload cnt/reload/mode from the inputs, stay in RUN and suppress time_out that cycle, including when cnt==0.
REQ-024 stop_i=1 SHALL send the channel to IDLE on the next edge with time_out_i=0, regardless of hold; stop SHALL take priority over start.
REQ-025 hold=1 SHALL freeze cnt and state in all channels, ignore start, and force time_out=0.
REQ-026 A pending expiry SHALL fire on the first edge after hold falls.
REQ-027 Counter arithmetic SHALL be unsigned modulo 2^WIDTH; cnt SHALL never decrement below 0.
REQ-028 Channels SHALL be fully independent; simultaneous expiries SHALL assert their time_out bits in the same cycle.
REQ-029 busy_i SHALL be 1 exactly when channel i is in RUN.
REQ-030 count SHALL be the registered cnt with no combinational path from inputs.

Reset
REQ-031 rst=1 SHALL immediately force all channels to IDLE, with cnt=0, reload=0, mode=0, time_out=0 and busy=0, independent of clk.
REQ-032 Reset asserted mid-RUN SHALL abort the channel with no time_out pulse.
REQ-033 After rst falls, a channel SHALL require a new start before counting.

Verification
REQ-034 Ch0 one-shot, n=5, start pulse at E0 -> busy=1 from E0, count goes 5,4,3,2,1,0, time_out high one cycle after E6, then busy=0.
REQ-035 Ch1 periodic, n=2 -> time_out pulses every 3 cycles for 4 periods; changing n to 7 mid-run SHALL keep the period at 3.
REQ-036 Ch0 n=4 with hold=1 for 3 cycles mid-count -> expiry SHALL be delayed by exactly 3 cycles, with no pulse during hold.
REQ-037 Retrigger and stop -> start while cnt==0 SHALL reload with no pulse; stop and start in the same cycle SHALL result in IDLE.
REQ-038 rst asserted between edges during RUN -> outputs SHALL clear immediately, and no time_out SHALL occur after release.
REQ-039 n=0 on ch2 and n=0 on ch3, started together -> both time_out bits SHALL be high in the same cycle, E0+1.
